bht_counter_table: RTL

// - Branch history table: per-lane 2-bit saturating counters indexed by fetch PC.
// - Consumed by the frontend predictor; trained by the resolved-branch record that the execute-stage

---
 rtl/bht_counter_table_pkg.sv | 43 ++++
 rtl/bht_counter_table_sat.sv | 17 +
 rtl/bht_counter_table.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bht_counter_table_pkg.sv
// Shared types for the branch history table: resolver record, prediction record,
// table entry layout and the clear FSM states.
package bht_counter_table_pkg;

  localparam int unsigned VLEN            = 64;
  localparam int unsigned INSTR_PER_FETCH = 2;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
    logic            is_mispredict;
    logic            is_taken;
    cf_t             cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } bht_state_e;

  // Weakly-not-taken, so a single taken training flips the prediction.
  localparam bht_entry_t BHT_ENTRY_RESET = '{valid: 1'b0, cnt: 2'b01};

endpackage

// File: rtl/bht_counter_table_sat.sv
// Next value of a 2-bit saturating branch counter; holds at 0 and 3.
module bht_sat_counter (
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/bht_counter_table.sv
// Branch history table: per-lane 2-bit counters indexed by fetch PC, trained by the
// branch resolver, with a row-by-row clear sequence started by flush_i.
module bht_counter_table #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = bht_counter_table_pkg::INSTR_PER_FETCH
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_ni,
  input  logic                                                         flush_i,
  input  logic                                                         debug_mode_i,
  input  logic [bht_counter_table_pkg::VLEN-1:0]                       vpc_i,
  input  bht_counter_table_pkg::bp_resolve_t                           resolved_branch_i,
  output bht_counter_table_pkg::bht_prediction_t [INSTR_PER_FETCH-1:0] bht_prediction_o,
  output logic                                                         busy_o
);

  import bht_counter_table_pkg::*;

  localparam int unsigned OFFSET    = 1;
  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned LANE_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned IDX_BITS  = ROW_BITS + LANE_BITS;

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);

  // Callers pass pc[OFFSET +: IDX_BITS]; upper PC bits alias onto the same entry.
  function automatic logic [ROW_BITS-1:0] row_of(input logic [IDX_BITS-1:0] idx_bits);
    return idx_bits[LANE_BITS +: ROW_BITS];
  endfunction

  function automatic logic [LANE_BITS-1:0] lane_of(input logic [IDX_BITS-1:0] idx_bits);
    return idx_bits[LANE_BITS-1:0];
  endfunction

  bht_entry_t          table_q [NR_ROWS][INSTR_PER_FETCH];
  bht_state_e          state_q;
  bht_state_e          state_d;
  logic [ROW_BITS-1:0] idx_q;
  logic [ROW_BITS-1:0] idx_d;
  logic                clear_row;

  logic [ROW_BITS-1:0]  pred_row;
  logic [ROW_BITS-1:0]  train_row;
  logic [LANE_BITS-1:0] train_lane;
  bht_entry_t           train_entry;
  logic [1:0]           train_cnt_next;
  logic                 train_en;

  logic unused_inputs;

  assign pred_row   = row_of(vpc_i[OFFSET +: IDX_BITS]);
  assign train_row  = row_of(resolved_branch_i.pc[OFFSET +: IDX_BITS]);
  assign train_lane = lane_of(resolved_branch_i.pc[OFFSET +: IDX_BITS]);

  assign unused_inputs = ^{vpc_i, resolved_branch_i};

  // A flush arriving together with a resolved branch takes priority; the branch is lost.
  assign train_en = resolved_branch_i.valid
                  && (resolved_branch_i.cf_type == Branch)
                  && !debug_mode_i
                  && (state_q == IDLE)
                  && !flush_i;

  assign train_entry = table_q[train_row][train_lane];

  bht_sat_counter u_sat_counter (
    .cnt      (train_entry.cnt),
    .taken    (resolved_branch_i.is_taken),
    .cnt_next (train_cnt_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clear_row = 1'b0;
    busy_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        busy_o    = 1'b1;
        clear_row = 1'b1;
        if (flush_i) begin
          idx_d = '0;
        end else if (idx_q == LAST_ROW) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ROW_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int r = 0; r < int'(NR_ROWS); r++) begin
        for (int l = 0; l < int'(INSTR_PER_FETCH); l++) begin
          table_q[r][l] <= BHT_ENTRY_RESET;
        end
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (clear_row) begin
        for (int l = 0; l < int'(INSTR_PER_FETCH); l++) begin
          table_q[idx_q][l] <= BHT_ENTRY_RESET;
        end
      end else if (train_en) begin
        table_q[train_row][train_lane] <= '{valid: 1'b1, cnt: train_cnt_next};
      end
    end
  end

  // Reads the registered table only, so a write this cycle shows up next cycle.
  always_comb begin
    bht_prediction_o = '0;
    for (int l = 0; l < int'(INSTR_PER_FETCH); l++) begin
      bht_prediction_o[l].valid = table_q[pred_row][l].valid & ~busy_o;
      bht_prediction_o[l].taken = table_q[pred_row][l].cnt[1] & ~busy_o;
    end
  end

endmodule
